// File: rtl/sw_frame_pkg.sv
// Shared definitions for the SOP/ID/LEN/DATA/EOP switch-control stream format.
// The frame transmitter and the frame receiver both import this package.
package sw_frame_pkg;

  // Frame delimiter words
  localparam logic [15:0] SOP_WORD = 16'h0a0a;
  localparam logic [15:0] EOP_WORD = 16'h0b0b;

  // Words ahead of the payload: SOP, ID, LEN
  localparam int FRAME_HDR_WORDS = 3;

  // Framer / parser state encoding. CSUM is only reachable in checksum builds.
  typedef enum logic [2:0] {
    LOAD,
    DROP,
    SOP,
    ID,
    LEN,
    DATA,
    EOP,
    CSUM
  } frame_state_e;

endpackage

// File: rtl/sw_frame_buf.sv
// Payload buffer: DEPTH x DATA_WIDTH simple dual-port RAM.
// Synchronous write port, asynchronous (combinational) read port so the
// framer can load the next payload word into its output register in the
// same cycle as the downstream handshake. Contents are never cleared.
module sw_frame_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store one payload word per accepted beat
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sw_frame_tx.sv
// Packet framer, transmit side of the switch-control stream format.
// Buffers one whole payload packet, then emits SOP, ID, LEN, payload, EOP.
// Optional build macro SW_FRAME_TX_CHECKSUM_EN inserts a CSUM word (16-bit
// wrap-around sum of ID, LEN and payload) between the payload and EOP.
module sw_frame_tx
  import sw_frame_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] SOP_WORD   = sw_frame_pkg::SOP_WORD,
  parameter logic [DATA_WIDTH-1:0] EOP_WORD   = sw_frame_pkg::EOP_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] frame_id,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [1:0]            s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  frame_state_e          state_reg, state_next;
  logic [CW-1:0]         wr_cnt_reg, wr_cnt_next;
  logic [CW-1:0]         rd_cnt_reg, rd_cnt_next;
  logic [CW-1:0]         len_reg, len_next;
  logic [DATA_WIDTH-1:0] id_reg, id_next;
  logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
  logic                  tvalid_reg, tvalid_next;
  logic                  tlast_reg, tlast_next;
  logic                  err_reg, err_next;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [CW-1:0]         wr_cnt_inc;
  logic                  s_hs, m_hs;
  logic                  unused_tkeep;
`ifdef SW_FRAME_TX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_reg, csum_next;
`endif

  // Byte enables on the slave side carry no information for this block
  assign unused_tkeep = ^s_axis_tkeep;

  assign s_axis_tready = ~reset & ((state_reg == LOAD) | (state_reg == DROP));
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = tvalid_reg & m_axis_tready;
  assign wr_cnt_inc    = wr_cnt_reg + CW'(1);

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tkeep  = tvalid_reg ? 2'b11 : 2'b00;
  assign busy          = (state_reg != LOAD) & (state_reg != DROP);
  assign err_overflow  = err_reg;

  sw_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_reg[AW-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_cnt_reg[AW-1:0]),
    .rdata (buf_rdata)
  );

  // State, counters and the output register; reset abandons any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= LOAD;
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      len_reg    <= '0;
      id_reg     <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      err_reg    <= 1'b0;
`ifdef SW_FRAME_TX_CHECKSUM_EN
      csum_reg   <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      rd_cnt_reg <= rd_cnt_next;
      len_reg    <= len_next;
      id_reg     <= id_next;
      tdata_reg  <= tdata_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      err_reg    <= err_next;
`ifdef SW_FRAME_TX_CHECKSUM_EN
      csum_reg   <= csum_next;
`endif
    end
  end

  // Next state: each output handshake loads the following word directly, no bubble
  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    rd_cnt_next = rd_cnt_reg;
    len_next    = len_reg;
    id_next     = id_reg;
    tdata_next  = tdata_reg;
    tvalid_next = tvalid_reg;
    tlast_next  = tlast_reg;
    err_next    = 1'b0;
    buf_we      = 1'b0;
`ifdef SW_FRAME_TX_CHECKSUM_EN
    csum_next   = csum_reg;
`endif
    case (state_reg)
      LOAD: begin
        if (s_hs) begin
          buf_we      = 1'b1;
          wr_cnt_next = wr_cnt_inc;
`ifdef SW_FRAME_TX_CHECKSUM_EN
          csum_next   = csum_reg + s_axis_tdata;
`endif
          if (s_axis_tlast) begin
            id_next     = frame_id;
            len_next    = wr_cnt_inc;
            tdata_next  = SOP_WORD;
            tvalid_next = 1'b1;
            state_next  = SOP;
`ifdef SW_FRAME_TX_CHECKSUM_EN
            csum_next   = csum_reg + s_axis_tdata + frame_id
                          + {{(DATA_WIDTH-CW){1'b0}}, wr_cnt_inc};
`endif
          end else if (wr_cnt_reg == LAST_IDX) begin
            state_next = DROP;
          end
        end
      end
      DROP: begin
        if (s_hs && s_axis_tlast) begin
          err_next    = 1'b1;
          wr_cnt_next = '0;
          state_next  = LOAD;
`ifdef SW_FRAME_TX_CHECKSUM_EN
          csum_next   = '0;
`endif
        end
      end
      SOP: begin
        if (m_hs) begin
          tdata_next = id_reg;
          state_next = ID;
        end
      end
      ID: begin
        if (m_hs) begin
          tdata_next = {{(DATA_WIDTH-CW){1'b0}}, len_reg};
          state_next = LEN;
        end
      end
      LEN: begin
        if (m_hs) begin
          tdata_next  = buf_rdata;
          rd_cnt_next = rd_cnt_reg + CW'(1);
          state_next  = DATA;
        end
      end
      DATA: begin
        if (m_hs) begin
          if (rd_cnt_reg == len_reg) begin
`ifdef SW_FRAME_TX_CHECKSUM_EN
            tdata_next = csum_reg;
            state_next = CSUM;
`else
            tdata_next = EOP_WORD;
            tlast_next = 1'b1;
            state_next = EOP;
`endif
          end else begin
            tdata_next  = buf_rdata;
            rd_cnt_next = rd_cnt_reg + CW'(1);
          end
        end
      end
`ifdef SW_FRAME_TX_CHECKSUM_EN
      CSUM: begin
        if (m_hs) begin
          tdata_next = EOP_WORD;
          tlast_next = 1'b1;
          state_next = EOP;
        end
      end
`endif
      EOP: begin
        if (m_hs) begin
          tdata_next  = '0;
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          wr_cnt_next = '0;
          rd_cnt_next = '0;
          state_next  = LOAD;
`ifdef SW_FRAME_TX_CHECKSUM_EN
          csum_next   = '0;
`endif
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

endmodule
